// File: rtl/mc_ctrl_pkg.sv
// Package mc_ctrl_pkg: shared types for the multicycle ARM control unit.
//   - state_t    : main FSM states (UNKNOWN only exists with MC_CTRL_UNKNOWN_TRAP_EN)
//   - alu_ctl_e, srca_e, srcb_e, res_e : datapath select encodings
//   - op_e, cond_e, CMD_* : instruction field encodings
//   - cond_holds : ARM condition-code evaluation against NZCV
package mc_ctrl_pkg;

  localparam int unsigned ST_BITS = 4;

  typedef enum logic [ST_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWR    = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
`ifdef MC_CTRL_UNKNOWN_TRAP_EN
    , S_UNKNOWN = 4'd10
`endif
  } state_t;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_ctl_e;
  typedef enum logic [1:0] {SRCA_REG = 2'b00, SRCA_PC = 2'b01} srca_e;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10} res_e;
  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UNK = 2'b11} op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, hold;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: hold = z;
      COND_NE: hold = ~z;
      COND_CS: hold = c;
      COND_CC: hold = ~c;
      COND_MI: hold = n;
      COND_PL: hold = ~n;
      COND_VS: hold = v;
      COND_VC: hold = ~v;
      COND_HI: hold = c & ~z;
      COND_LS: hold = ~c | z;
      COND_GE: hold = (n == v);
      COND_LT: hold = (n != v);
      COND_GT: hold = ~z & (n == v);
      COND_LE: hold = z | (n != v);
      COND_AL: hold = 1'b1;
      default: hold = 1'b0;
    endcase
    return hold;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Interface mc_ctrl_fsm_if: controller <-> datapath bundle.
//   Instr[31:12], ALUFlags (datapath -> controller)
//   PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
//   ResultSrc, ImmSrc, ALUControl, illegal_instr (controller -> datapath)
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic [1:0]   RegSrc;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   ImmSrc;
  logic [1:0]   ALUControl;
  logic         illegal_instr;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_instr
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_instr
  );
endinterface

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV flag register, condition evaluation and write gating.
//   clk, reset     : clock, async active-high reset
//   cond           : instruction condition field
//   alu_flags      : NZCV from the ALU this cycle
//   flag_w         : [1]=NZ write, [0]=CV write request from the ALU decoder
//   cond_capture   : latch the condition result (asserted in DECODE)
//   next_pc/branch/reg_w/mem_w : ungated FSM requests
//   pc_write/reg_write/mem_write : gated enables to the datapath
module mc_cond_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       cond_capture,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  // Flag updates are gated by the registered condition, so an instruction's
  // own flag write cannot change whether its writeback happens.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (flag_w[1] && cond_ex_q) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] && cond_ex_q) flags_d[1:0] = alu_flags[1:0];
    if (cond_capture) cond_ex_d = cond_holds(cond, flags_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= FLAG_RST;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign pc_write  = next_pc | (branch & cond_ex_q);
  assign reg_write = reg_w & cond_ex_q;
  assign mem_write = mem_w & cond_ex_q;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle ARM control unit (main Moore FSM + ALU decoder),
// with condition/flag handling in mc_cond_unit.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH
//   bus   : mc_ctrl_fsm_if.master (Instr/ALUFlags in, all datapath controls out)
// Build option: MC_CTRL_UNKNOWN_TRAP_EN makes op=11 trap into a sticky
// UNKNOWN state with illegal_instr=1; otherwise op=11 is a NOP.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W  = 4,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_fsm_if.master bus
);

  if (STATE_W < ST_BITS) begin : g_state_w_chk
    $error("mc_ctrl_fsm: STATE_W too small for the state encoding");
  end

  state_t     state_q, state_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic       ir_write, adr_src, cmd_known;
  srca_e      alu_src_a;
  srcb_e      alu_src_b;
  res_e       result_src;
  alu_ctl_e   alu_ctl;
  logic [1:0] flag_w;
  logic       unused_instr_bits;

  assign op                = bus.Instr[27:26];
  assign funct             = bus.Instr[25:20];
  assign unused_instr_bits = ^bus.Instr[19:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
`ifdef MC_CTRL_UNKNOWN_TRAP_EN
          default: state_d = S_UNKNOWN;
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
`ifdef MC_CTRL_UNKNOWN_TRAP_EN
      S_UNKNOWN:  state_d = S_UNKNOWN;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_MEMADR:   alu_src_b = SRCB_IMM;
      S_MEMRD:    adr_src = 1'b1;
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = 1'b1;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: unrecognised commands fall back to ADD with no flag write.
  always_comb begin
    alu_ctl   = ALU_ADD;
    cmd_known = 1'b1;
    flag_w    = '0;
    if (alu_op) begin
      case (funct[4:1])
        CMD_ADD: alu_ctl = ALU_ADD;
        CMD_SUB: alu_ctl = ALU_SUB;
        CMD_AND: alu_ctl = ALU_AND;
        CMD_ORR: alu_ctl = ALU_ORR;
        default: cmd_known = 1'b0;
      endcase
      flag_w[1] = funct[0] & cmd_known;
      flag_w[0] = funct[0] & cmd_known & ((alu_ctl == ALU_ADD) | (alu_ctl == ALU_SUB));
    end
  end

  mc_cond_unit #(.FLAG_RST(FLAG_RST)) u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond         (bus.Instr[31:28]),
    .alu_flags    (bus.ALUFlags),
    .flag_w       (flag_w),
    .cond_capture (state_q == S_DECODE),
    .next_pc      (next_pc),
    .branch       (branch),
    .reg_w        (reg_w),
    .mem_w        (mem_w),
    .pc_write     (bus.PCWrite),
    .reg_write    (bus.RegWrite),
    .mem_write    (bus.MemWrite)
  );

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_ctl;
`ifdef MC_CTRL_UNKNOWN_TRAP_EN
  assign bus.illegal_instr = (state_q == S_UNKNOWN);
`else
  assign bus.illegal_instr = 1'b0;
`endif

endmodule
